// File: rtl/hls_deadlock_persist_monitor.sv
// -----------------------------------------------------------------------------
// hls_deadlock_persist_monitor
//
// Deadlock monitor for an HLS dataflow region.
//
// A channel counts as blocked only when its AXIS stall is asserted, the
// owning process is not idle, and the runtime mask enables it. Any child
// instance block input also counts. That combined "raw" block condition
// must hold for THRESH consecutive cycles before the monitor declares
// deadlock. At onset the monitor records the lowest blocking channel, and it
// counts how many times it has entered the locked state.
//
// Ports
//   clock            clock
//   reset            synchronous, active-high reset (clears everything)
//   axis_block_sigs  [N_AXIS] per-channel AXIS stall (full/empty)
//   inst_idle_sigs   [N_AXIS] per-channel owning-process idle (masks stall)
//   inst_block_sigs  [N_INST] block outputs of child monitors
//   chan_mask        [N_AXIS] 1 = channel monitored
//   clear            synchronous clear of lock state, pcnt and first_chan
//   block            registered deadlock flag
//   first_chan       [IDX_W] lowest blocking channel at onset;
//                            N_AXIS means the block came from instances only
//   lock_count       [8] number of entries into LOCKED, saturating at 255
//
// Configuration macro
//   DEADLOCK_MONITOR_STICKY_EN : when defined, LOCKED is left only through
//                                clear or reset. When undefined (default),
//                                LOCKED falls back to IDLE as soon as raw
//                                drops.
// -----------------------------------------------------------------------------
module hls_deadlock_persist_monitor #(
  parameter int N_AXIS = 7,
  parameter int N_INST = 1,
  parameter int THRESH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_AXIS-1:0]                 axis_block_sigs,
  input  logic [N_AXIS-1:0]                 inst_idle_sigs,
  input  logic [N_INST-1:0]                 inst_block_sigs,
  input  logic [N_AXIS-1:0]                 chan_mask,
  input  logic                              clear,
  output logic                              block,
  output logic [$clog2(N_AXIS+1)-1:0]       first_chan,
  output logic [7:0]                        lock_count
);

  localparam int IDX_W  = $clog2(N_AXIS + 1);
  localparam int PCNT_W = $clog2(THRESH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUSPECT = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    first_q, first_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                block_q, block_d;

  logic [N_AXIS-1:0]   qual_axis;
  logic                raw;
  logic [IDX_W-1:0]    low_idx;
  logic                enter_lock;

  // Combinational block condition; mask changes act in the same cycle.
  assign qual_axis = axis_block_sigs & ~inst_idle_sigs & chan_mask;
  assign raw       = (|qual_axis) | (|inst_block_sigs);

  // Lowest qualified channel; N_AXIS when only instance inputs block.
  always_comb begin
    low_idx = IDX_W'(N_AXIS);
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (qual_axis[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    first_d    = first_q;
    cnt_d      = cnt_q;
    enter_lock = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (raw) begin
          first_d = low_idx;
          if (THRESH == 1) begin
            state_d    = S_LOCKED;
            enter_lock = 1'b1;
          end else begin
            state_d = S_SUSPECT;
            pcnt_d  = PCNT_W'(1);
          end
        end
      end
      S_SUSPECT: begin
        if (!raw) begin
          state_d = S_IDLE;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
          if (pcnt_q == PCNT_W'(THRESH - 1)) begin
            state_d    = S_LOCKED;
            enter_lock = 1'b1;
          end
        end
      end
      S_LOCKED: begin
`ifdef DEADLOCK_MONITOR_STICKY_EN
        state_d = S_LOCKED;
`else
        if (!raw) begin
          state_d = S_IDLE;
          pcnt_d  = '0;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        pcnt_d  = '0;
      end
    endcase

    if (enter_lock && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end

    // Clear overrides any same-cycle threshold event, so no lock is counted.
    if (clear) begin
      state_d = S_IDLE;
      pcnt_d  = '0;
      first_d = '0;
      cnt_d   = cnt_q;
    end

    block_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      first_q <= '0;
      cnt_q   <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign block      = block_q;
  assign first_chan = first_q;
  assign lock_count = cnt_q;

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for hls_deadlock_persist_monitor (N_AXIS=7, N_INST=1, THRESH=4).
// A run-length reference model tracks consecutive raw samples; a compare
// process checks block/first_chan/lock_count against it every cycle, and the
// directed scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_hls_deadlock_persist_monitor;

  localparam int N_AXIS = 7;
  localparam int N_INST = 1;
  localparam int THRESH = 4;
  localparam int IDX_W  = $clog2(N_AXIS + 1);
`ifdef DEADLOCK_MONITOR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_AXIS-1:0] inst_idle_sigs;
  logic [N_INST-1:0] inst_block_sigs;
  logic [N_AXIS-1:0] chan_mask;
  logic              clear;
  logic              block;
  logic [IDX_W-1:0]  first_chan;
  logic [7:0]        lock_count;

  hls_deadlock_persist_monitor #(
    .N_AXIS(N_AXIS),
    .N_INST(N_INST),
    .THRESH(THRESH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs (inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .chan_mask      (chan_mask),
    .clear          (clear),
    .block          (block),
    .first_chan     (first_chan),
    .lock_count     (lock_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model state
  bit m_locked = 1'b0;
  int m_run    = 0;
  int m_fc     = 0;
  int m_cnt    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_chan(input logic [N_AXIS-1:0] q);
    for (int i = 0; i < N_AXIS; i++) begin
      if (q[i]) return i;
    end
    return N_AXIS;
  endfunction

  // Model: deadlock is declared once raw has been seen THRESH times in a row.
  initial begin
    forever begin
      logic [N_AXIS-1:0] q;
      bit r;
      @(posedge clock);
      q = axis_block_sigs & ~inst_idle_sigs & chan_mask;
      r = (q != '0) || (inst_block_sigs != '0);
      if (reset === 1'b1) begin
        m_locked = 1'b0; m_run = 0; m_fc = 0; m_cnt = 0;
      end else if (clear === 1'b1) begin
        m_locked = 1'b0; m_run = 0; m_fc = 0;
      end else if (m_locked) begin
        if (!STICKY && !r) begin
          m_locked = 1'b0; m_run = 0;
        end
      end else if (r) begin
        if (m_run == 0) m_fc = lowest_chan(q);
        m_run++;
        if (m_run >= THRESH) begin
          m_locked = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (check_en) begin
        chk("model_block", int'(block), int'(m_locked));
        chk("model_first_chan", int'(first_chan), m_fc);
        chk("model_lock_count", int'(lock_count), m_cnt);
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    axis_block_sigs = '0;
    inst_idle_sigs  = '0;
    inst_block_sigs = '0;
    chan_mask       = '1;
    clear           = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    int hold;
    reset = 1'b1;
    idle_inputs();
    tick(2);
    check_en = 1'b1;
    reset = 1'b0;

    // Reset state
    chk("reset_block", int'(block), 0);
    chk("reset_first_chan", int'(first_chan), 0);
    chk("reset_lock_count", int'(lock_count), 0);
    $display("reset: block=%0d first_chan=%0d lock_count=%0d", block, first_chan, lock_count);

    // T1: ch3 blocked 4 cycles -> lock on the 4th sample
    axis_block_sigs = 7'b000_1000;
    tick(3);
    chk("t1_block_before", int'(block), 0);
    tick(1);
    chk("t1_block", int'(block), 1);
    chk("t1_first_chan", int'(first_chan), 3);
    chk("t1_lock_count", int'(lock_count), 1);
    $display("T1: block=%0d first_chan=%0d lock_count=%0d", block, first_chan, lock_count);

    // T6: raw drops while locked
    axis_block_sigs = '0;
    tick(1);
    chk("t6_block_after_drop", int'(block), STICKY ? 1 : 0);
    chk("t6_first_chan_kept", int'(first_chan), 3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t6_clear_block", int'(block), 0);
    chk("t6_clear_first_chan", int'(first_chan), 0);
    chk("t6_clear_keeps_count", int'(lock_count), 1);
    $display("T6: sticky=%0d block=%0d lock_count=%0d", STICKY, block, lock_count);

    // T2: ch2 blocked only 3 cycles
    do_reset();
    axis_block_sigs = 7'b000_0100;
    tick(3);
    axis_block_sigs = '0;
    tick(5);
    chk("t2_block", int'(block), 0);
    chk("t2_lock_count", int'(lock_count), 0);
    $display("T2: block=%0d lock_count=%0d", block, lock_count);

    // T3: ch5 stalled but idle, then stalled but masked
    axis_block_sigs = 7'b010_0000;
    inst_idle_sigs  = 7'b010_0000;
    tick(50);
    chk("t3_idle_block", int'(block), 0);
    inst_idle_sigs = '0;
    chan_mask      = 7'b101_1111;
    tick(50);
    chk("t3_mask_block", int'(block), 0);
    chk("t3_lock_count", int'(lock_count), 0);
    $display("T3: block=%0d lock_count=%0d", block, lock_count);

    // T4: instance-only block
    idle_inputs();
    inst_block_sigs = 1'b1;
    tick(4);
    chk("t4_block", int'(block), 1);
    chk("t4_first_chan", int'(first_chan), N_AXIS);
    chk("t4_lock_count", int'(lock_count), 1);
    $display("T4: block=%0d first_chan=%0d lock_count=%0d", block, first_chan, lock_count);

    // T5: clear while raw still high, then re-lock
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t5_clear_block", int'(block), 0);
    tick(3);
    chk("t5_relock_early", int'(block), 0);
    tick(1);
    chk("t5_relock_block", int'(block), 1);
    chk("t5_lock_count", int'(lock_count), 2);
    chk("t5_first_chan", int'(first_chan), N_AXIS);
    $display("T5: block=%0d lock_count=%0d", block, lock_count);

    // Saturation: 300 lock events
    do_reset();
    idle_inputs();
    axis_block_sigs = 7'b000_0010;
    for (int i = 0; i < 300; i++) begin
      tick(4);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
    end
    chk("sat_lock_count", int'(lock_count), 255);
    $display("SAT: lock_count=%0d", lock_count);

    // Randomised traffic checked by the model every cycle
    do_reset();
    idle_inputs();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        logic [N_AXIS-1:0] b;
        for (int i = 0; i < N_AXIS; i++) b[i] = ($urandom_range(0, 5) == 0);
        axis_block_sigs = b;
        for (int i = 0; i < N_AXIS; i++) b[i] = ($urandom_range(0, 7) == 0);
        inst_idle_sigs = b;
        for (int i = 0; i < N_AXIS; i++) b[i] = ($urandom_range(0, 4) != 0);
        chan_mask = b;
        inst_block_sigs = ($urandom_range(0, 9) == 0);
        hold = $urandom_range(1, 8);
      end
      hold--;
      clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 1'b0;
    clear = 1'b0;
    tick(2);
    $display("RANDOM: done, lock_count=%0d", lock_count);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
